// File: rtl/pixel_queue_encoder_pkg.sv
// Shared global definitions for the pixel queue encoder: image geometry,
// activity threshold, queue sizing and the controller state encoding.
package pixel_queue_encoder_pkg;

    localparam int IMAGE_PIXELS_DEFAULT    = 784;
    localparam int PIXEL_THRESHOLD_DEFAULT = 128;
    localparam int QUEUE_DEPTH_DEFAULT     = 1024;
    localparam int ADDR_W                  = 10;

    typedef enum logic [0:0] {
        SCAN    = 1'b0,
        PUBLISH = 1'b1
    } state_t;

endpackage

// File: rtl/pixel_queue_encoder_fifo.sv
// First-word-fall-through address queue. Pointers carry an extra wrap bit so
// full and empty are distinguishable; writes when full and reads when empty
// are silently dropped. A simultaneous write and read keeps the count.
module address_fifo
    import pixel_queue_encoder_pkg::*;
#(
    parameter int DEPTH  = QUEUE_DEPTH_DEFAULT,
    parameter int DATA_W = ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write,
    input  logic [DATA_W-1:0]        write_data,
    input  logic                     read,
    output logic                     empty,
    output logic                     full,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W:0]    wr_ptr;
    logic [IDX_W:0]    rd_ptr;
    logic              do_write;
    logic              do_read;

    // Status and head decode; the head reads 0 whenever nothing is queued.
    always_comb begin
        empty    = (wr_ptr == rd_ptr);
        full     = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
        count    = wr_ptr - rd_ptr;
        do_write = write && !full;
        do_read  = read && !empty;
        head     = empty ? '0 : mem[rd_ptr[IDX_W-1:0]];
    end

    // Pointer advance; wrap is natural modulo 2*DEPTH on the extended pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (do_read)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr[IDX_W-1:0]] <= write_data;
    end

endmodule

// File: rtl/pixel_queue_encoder.sv
// Scans a raster image, queues the addresses of pixels at or above the
// threshold, then publishes the queue to Layer 1 until it is drained.
// Handshake: a pixel transfers on a rising edge with pixelValid=1 and
// pixelReady=1; a pop happens on a rising edge with dequeue=1 while
// inputsReady=1 and queueEmpty=0, anything else on dequeue is ignored.
module pixel_queue_encoder
    import pixel_queue_encoder_pkg::*;
#(
    parameter int IMAGE_PIXELS    = IMAGE_PIXELS_DEFAULT,
    parameter int PIXEL_THRESHOLD = PIXEL_THRESHOLD_DEFAULT,
    parameter int QUEUE_DEPTH     = QUEUE_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pixelValid,
    input  logic [7:0]        pixelIn,
    output logic              pixelReady,
    input  logic              dequeue,
    output logic              inputsReady,
    output logic              queueEmpty,
    output logic [ADDR_W-1:0] queueOut,
    output logic [ADDR_W-1:0] activeCount,
    output logic              emptyImage,
    output state_t            debug_state
);

    localparam logic [7:0]        THRESH    = 8'(PIXEL_THRESHOLD);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_PIXELS - 1);
    localparam int                CNT_W     = $clog2(QUEUE_DEPTH) + 1;

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  addr;
    logic               accept;
    logic               is_active;
    logic               last_pixel;
    logic               image_has_active;
    logic               pop;
    logic               pop_last;
    logic               queue_full;
    logic [CNT_W-1:0]   queue_count;

    // Pixel and pop qualifiers shared by the FSM and datapath.
    always_comb begin
        accept           = pixelValid && pixelReady;
        is_active        = (pixelIn >= THRESH);
        last_pixel       = (addr == LAST_ADDR);
        image_has_active = (activeCount != '0) || is_active;
        pop              = dequeue && (state == PUBLISH) && !queueEmpty;
        pop_last         = pop && (queue_count == CNT_W'(1));
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= SCAN;
        else       state <= state_next;
    end

    // Next state: publish after a non-empty image, rescan once drained.
    always_comb begin
        state_next = state;
        case (state)
            SCAN:    if (accept && last_pixel && image_has_active) state_next = PUBLISH;
            PUBLISH: if (pop_last) state_next = SCAN;
            default: state_next = SCAN;
        endcase
    end

    // Outputs decoded from state; nothing is accepted while reset is held.
    always_comb begin
        pixelReady  = (state == SCAN) && !reset;
        inputsReady = (state == PUBLISH);
        debug_state = state;
    end

    // Address counter, active count and the empty-image pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr        <= '0;
            activeCount <= '0;
            emptyImage  <= 1'b0;
        end else begin
            emptyImage <= accept && last_pixel && !image_has_active;
            if (accept) begin
                addr <= last_pixel ? '0 : addr + 1'b1;
                if (last_pixel && !image_has_active) activeCount <= '0;
                else if (is_active)                  activeCount <= activeCount + 1'b1;
            end else if (pop_last) begin
                addr        <= '0;
                activeCount <= '0;
            end
        end
    end

    address_fifo #(
        .DEPTH  (QUEUE_DEPTH),
        .DATA_W (ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .write      (accept && is_active && !queue_full),
        .write_data (addr),
        .read       (pop),
        .empty      (queueEmpty),
        .full       (queue_full),
        .head       (queueOut),
        .count      (queue_count)
    );

endmodule
